ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Upstream neighbour of the master-to-slave address/control mux.
- Decides which AHB master owns the shared bus and drives Hmaster, the 2-bit select that steers the mux.
- Round-robin arbitration among up to 4 masters, with a default master, burst-aware handover and locked-transfer support.
- Observes the muxed Htrans/Hburst plus Hready so that a fixed-length burst is never broken.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; legal range 2..4 because Hmaster is fixed at 2 bits.
- DEFAULT_MASTER, 0, index granted when no master requests.

Ports:
- Hclk  input  1  bus clock; all state updates on the rising edge.
- Hresetn  input  1  asynchronous active-low reset.
- Hbusreq  input  NUM_MASTERS  per-master bus request, bit i belongs to master i.
- Hlock  input  NUM_MASTERS  per-master locked-access request.
- Htrans  input  2  muxed transfer type of the current owner: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- Hburst  input  3  muxed burst type: SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7.
- Hready  input  1  transfer-complete from the slave-side response mux.
- Hgrant  output  NUM_MASTERS  one-hot registered grant.
- Hmaster  output  2  registered index of the master owning the address phase; feeds the mux.
- Hmastlock  output  1  registered lock indication for the current address phase.

Behaviour:
- Reset (async, Hresetn=0):
  - Hgrant = one-hot(DEFAULT_MASTER); Hmaster = DEFAULT_MASTER; Hmastlock = 0.
  - Internal grant index = DEFAULT_MASTER; beat counter remain = 0.
  - Takes effect immediately. Normal behaviour resumes at the first rising edge after deassertion.
  - Reset mid-burst abandons the burst with no memory of it.
- Hready=0: all registers (Hgrant, Hmaster, Hmastlock, remain) hold.
- Beat counter, updated only on edges with Hready=1:
  - NONSEQ loads remain = len-1. len = 4, 8 or 16 for the fixed bursts; len = 1 for SINGLE and for INCR (undefined-length bursts may be re-arbitrated at any beat).
  - SEQ decrements remain, saturating at 0.
  - IDLE and BUSY leave remain unchanged.
- next_remain is the combinational value remain would take at this edge.
- Arbitration window: an edge with Hready=1 AND next_remain<=1 AND NOT (Hlock[grant_idx] & Hbusreq[grant_idx]).
  - Inside the window, Hgrant/grant_idx take the arbitration result.
  - Outside the window, Hgrant holds.
- Arbitration result (combinational):
  - Round-robin search from (grant_idx+1) mod NUM_MASTERS upward with wrap; the first index with Hbusreq set wins.
  - The current owner has lowest priority but wins if it is the sole requester.
  - No requests: DEFAULT_MASTER.
- Handover: on every edge with Hready=1, Hmaster <= grant_idx and Hmastlock <= Hlock[grant_idx] & Hbusreq[grant_idx].
  - Hmaster therefore trails a grant change by exactly one Hready-qualified edge.
  - This gives the old owner one more address beat; for a 4-beat burst that is its final SEQ.
- Lock: while the owner holds Hlock and Hbusreq, no re-arbitration occurs. This applies even in IDLE and across burst boundaries.
- Simultaneous events:
  - Request and lock rising in the same cycle: treated as an ordinary request.
  - Owner dropping Hbusreq mid fixed burst: grant held until the window opens.
- Hgrant is always exactly one-hot. Hmaster is always < NUM_MASTERS.

Test Plan:
- Reset then idle: Hbusreq=0000 for 5 cycles, Hready=1 -> Hgrant=0001, Hmaster=0, Hmastlock=0 throughout; async reset pulse mid-cycle clears outputs without a clock edge.
- Round-robin: owner 0, Hbusreq=1111, each master issuing SINGLE NONSEQ -> grant sequence 1,2,3,0,1 on consecutive Hready edges; Hmaster follows one edge later.
- INCR4 protection: master 1 owns, NONSEQ+3×SEQ with Hburst=3 while Hbusreq=0110 -> Hgrant moves to master 2 only on the edge accepting the 3rd beat; Hmaster=2 on the edge accepting the 4th beat.
- Wait states: same INCR4 with Hready=0 for 2 cycles on beat 2 -> Hgrant, Hmaster and remain frozen during the wait; handover is still after beat 4.
- Lock: master 3 asserts Hlock+Hbusreq over two INCR4 bursts with Hbusreq=1111 -> Hgrant stays 1000, Hmastlock=1; lock released -> next window grants master 0.
- Default master and single requester: only master 2 requests continuously -> stays granted indefinitely; it drops its request -> next window returns grant to master 0.

Source files
------------

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//   Round-robin AHB bus arbiter for 2..4 masters. It has a default master,
//   keeps fixed-length bursts intact, and supports locked transfers. The
//   registered Hmaster output steers the downstream address/control mux.
//
//   Ports
//     Hclk       bus clock, rising-edge state updates
//     Hresetn    asynchronous active-low reset
//     Hbusreq    per-master bus request (bit i = master i)
//     Hlock      per-master locked-access request
//     Htrans     muxed transfer type of the current owner
//     Hburst     muxed burst type of the current owner
//     Hready     transfer-complete; every register holds while low
//     Hgrant     one-hot registered grant
//     Hmaster    registered index of the address-phase owner
//     Hmastlock  registered lock flag for the current address phase
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [1:0]             Hmaster,
    output logic                   Hmastlock
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_OH  = 4'b0001 << DEFAULT_MASTER;

    // The request and lock vectors are widened to 4 bits so that a 2-bit
    // index can never select past the end for NUM_MASTERS < 4. The padding
    // bits are zero, which means they never request.
    logic [3:0] req_pad;
    logic [3:0] lock_pad;

    logic [1:0] grant_idx;
    logic [3:0] remain;
    logic [3:0] next_remain;
    logic [3:0] burst_last;
    logic       owner_locked;
    logic       arb_window;

    logic [1:0] arb_idx;
    logic       arb_found;
    logic [3:0] arb_oh;
    int         cand;

    assign req_pad  = 4'(Hbusreq);
    assign lock_pad = 4'(Hlock);

    assign owner_locked = req_pad[grant_idx] & lock_pad[grant_idx];

    // Beats left after the first one. Undefined-length INCR is treated like
    // SINGLE, so it can be re-arbitrated at any beat.
    always_comb begin
        burst_last = 4'd0;
        case (Hburst)
            3'd0, 3'd1: burst_last = 4'd0;
            3'd2, 3'd3: burst_last = 4'd3;
            3'd4, 3'd5: burst_last = 4'd7;
            3'd6, 3'd7: burst_last = 4'd15;
            default:    burst_last = 4'd0;
        endcase
    end

    always_comb begin
        next_remain = remain;
        case (Htrans)
            TR_NONSEQ: next_remain = burst_last;
            TR_SEQ:    next_remain = (remain == 4'd0) ? 4'd0 : remain - 4'd1;
            TR_IDLE,
            TR_BUSY:   next_remain = remain;
            default:   next_remain = remain;
        endcase
    end

    // The window opens once the current beat is the last or next-to-last
    // of the burst. The grant then moves one beat early, and Hmaster trails
    // it by one edge, so the old owner still issues its final beat.
    assign arb_window = Hready && (next_remain <= 4'd1) && !owner_locked;

    // The search starts just after the owner and wraps. The owner itself is
    // the last candidate (k == NUM_MASTERS), so it wins only when nobody
    // else requests.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = DEF_IDX;
        cand      = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = (int'(grant_idx) + k) % NUM_MASTERS;
            if (!arb_found && req_pad[cand[1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[1:0];
            end
        end
    end

    assign arb_oh = 4'b0001 << arb_idx;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            grant_idx <= DEF_IDX;
            Hgrant    <= DEF_OH[NUM_MASTERS-1:0];
            Hmaster   <= DEF_IDX;
            Hmastlock <= 1'b0;
            remain    <= 4'd0;
        end else if (Hready) begin
            remain    <= next_remain;
            Hmaster   <= grant_idx;
            Hmastlock <= owner_locked;
            if (arb_window) begin
                grant_idx <= arb_idx;
                Hgrant    <= arb_oh[NUM_MASTERS-1:0];
            end
        end
    end

    a_grant_onehot: assert property (@(posedge Hclk) disable iff (!Hresetn)
        $onehot(Hgrant));
    a_master_range: assert property (@(posedge Hclk) disable iff (!Hresetn)
        (int'(Hmaster) < NUM_MASTERS));

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//   Self-checking bench for ahb_arbiter with 4 masters and default master 0.
//   A table of {inputs, expected outputs after the edge} records is applied
//   in order. Expected values go into a scoreboard queue when the inputs are
//   driven, and they are popped and compared one time unit after the edge.
//   The reset checks are written out by hand at the end.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NSQ  = 2'd2;
    localparam logic [1:0] SEQ  = 2'd3;

    logic       Hclk;
    logic       Hresetn;
    logic [3:0] Hbusreq;
    logic [3:0] Hlock;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic       Hready;
    logic [3:0] Hgrant;
    logic [1:0] Hmaster;
    logic       Hmastlock;

    typedef struct packed {
        logic [3:0] busreq;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [3:0] e_grant;
        logic [1:0] e_master;
        logic       e_lock;
    } vec_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (Hbusreq),
        .Hlock     (Hlock),
        .Htrans    (Htrans),
        .Hburst    (Hburst),
        .Hready    (Hready),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Hmastlock (Hmastlock)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cmp(input string name, input int idx, input logic [3:0] g,
                       input logic [1:0] m, input logic l, input exp_t e);
        checks++;
        if (g !== e.grant) begin
            errors++;
            $display("FAIL %s[%0d] Hgrant got %b exp %b", name, idx, g, e.grant);
        end
        checks++;
        if (m !== e.master) begin
            errors++;
            $display("FAIL %s[%0d] Hmaster got %0d exp %0d", name, idx, m, e.master);
        end
        checks++;
        if (l !== e.lock) begin
            errors++;
            $display("FAIL %s[%0d] Hmastlock got %b exp %b", name, idx, l, e.lock);
        end
    endtask

    task automatic add(input logic [3:0] br, input logic [3:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rd,
                       input logic [3:0] eg, input logic [1:0] em, input logic el);
        vec_t v;
        v.busreq = br; v.lock = lk; v.trans = tr; v.burst = bu; v.ready = rd;
        v.e_grant = eg; v.e_master = em; v.e_lock = el;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        Hbusreq = v.busreq;
        Hlock   = v.lock;
        Htrans  = v.trans;
        Hburst  = v.burst;
        Hready  = v.ready;
        e.grant = v.e_grant; e.master = v.e_master; e.lock = v.e_lock;
        sb_q.push_back(e);
        @(posedge Hclk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard[%0d] queue empty got 0 entries exp 1", idx);
        end else begin
            e = sb_q.pop_front();
            cmp("vec", idx, Hgrant, Hmaster, Hmastlock, e);
        end
    endtask

    task automatic chk_now(input string name, input logic [3:0] eg,
                           input logic [1:0] em, input logic el);
        exp_t e;
        e.grant = eg; e.master = em; e.lock = el;
        cmp(name, 0, Hgrant, Hmaster, Hmastlock, e);
    endtask

    initial begin
        Hresetn = 1'b0;
        Hbusreq = 4'b0; Hlock = 4'b0; Htrans = IDLE; Hburst = 3'd0; Hready = 1'b1;

        // idle: default master
        for (int i = 0; i < 5; i++) add(4'b0000, 4'b0, IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
        // round robin, SINGLE transfers from everyone
        add(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0);
        add(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0);
        add(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0);
        add(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0);
        // INCR4 by master 1 with master 2 waiting
        add(4'b0010, 4'b0, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, NSQ,  3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, SEQ,  3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, SEQ,  3'd3, 1'b1, 4'b0100, 2'd1, 1'b0);
        add(4'b0100, 4'b0, SEQ,  3'd3, 1'b1, 4'b0100, 2'd2, 1'b0);
        // same INCR4 with two wait states on beat 2
        add(4'b0010, 4'b0, IDLE, 3'd0, 1'b1, 4'b0010, 2'd2, 1'b0);
        add(4'b0010, 4'b0, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, NSQ,  3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, SEQ,  3'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, SEQ,  3'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, SEQ,  3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, SEQ,  3'd3, 1'b1, 4'b0100, 2'd1, 1'b0);
        add(4'b0100, 4'b0, SEQ,  3'd3, 1'b1, 4'b0100, 2'd2, 1'b0);
        // master 3 locks across two INCR4 bursts and an IDLE
        add(4'b1111, 4'b1000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0);
        add(4'b1111, 4'b1000, NSQ,  3'd3, 1'b1, 4'b1000, 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b1000, SEQ, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 4'b1000, NSQ,  3'd3, 1'b1, 4'b1000, 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b1000, SEQ, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 4'b1000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0);
        // sole requester master 2, then nobody
        add(4'b0100, 4'b0, NSQ, 3'd0, 1'b1, 4'b0100, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) add(4'b0100, 4'b0, NSQ, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0);
        add(4'b0000, 4'b0, IDLE, 3'd0, 1'b1, 4'b0001, 2'd2, 1'b0);
        add(4'b0000, 4'b0, IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
        // INCR8 by master 0, which drops its request after beat 1
        add(4'b0011, 4'b0, NSQ, 3'd5, 1'b1, 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) add(4'b0010, 4'b0, SEQ, 3'd5, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(4'b0010, 4'b0, SEQ, 3'd5, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(4'b0010, 4'b0, SEQ, 3'd5, 1'b1, 4'b0010, 2'd1, 1'b0);
        // undefined-length INCR re-arbitrates every beat
        add(4'b0011, 4'b0, NSQ, 3'd1, 1'b1, 4'b0001, 2'd1, 1'b0);
        add(4'b0011, 4'b0, SEQ, 3'd1, 1'b1, 4'b0010, 2'd0, 1'b0);
        // lock up master 3 and start an INCR16 before the reset
        add(4'b1000, 4'b1000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd1, 1'b0);
        add(4'b1000, 4'b1000, NSQ,  3'd7, 1'b1, 4'b1000, 2'd3, 1'b1);

        #12;
        chk_now("reset", 4'b0001, 2'd0, 1'b0);
        Hresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // async reset mid-cycle, with no clock edge involved
        #3;
        Hresetn = 1'b0;
        #1;
        chk_now("async_rst", 4'b0001, 2'd0, 1'b0);
        @(posedge Hclk);
        #1;
        chk_now("rst_hold", 4'b0001, 2'd0, 1'b0);
        #3;
        Hresetn = 1'b1;
        // the INCR16 is forgotten, so the window is open right away
        begin
            vec_t v;
            v = '{busreq: 4'b0010, lock: 4'b0, trans: IDLE, burst: 3'd0, ready: 1'b1,
                  e_grant: 4'b0010, e_master: 2'd0, e_lock: 1'b0};
            apply(v, 900);
            v.e_master = 2'd1;
            apply(v, 901);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
